csram_arbiter: RTL and testbench
================================

CSRAM_ARBITER -- requirements
Module: csram_arbiter

Interface
REQ-001 Parameter NUM_NEURONS, default 256: CSRAM depth; AW = $clog2(NUM_NEURONS).
REQ-002 Parameter DATA_WIDTH, default 64: CSRAM word width.
REQ-003 Parameter MAX_WAIT, default 15: config-port wait threshold in cycles; WW = $clog2(MAX_WAIT+1).
REQ-004 Clock and reset are clk (input, 1) and rst (input, 1); one clock; reset is synchronous and active-low.
REQ-005 core_req  in  1  core controller requests a CSRAM access.
REQ-006 core_lock  in  1  core holds ownership across a read-modify-write pair.
REQ-007 core_we / core_addr / core_wdata  in  1 / AW / DATA_WIDTH  core access fields, stable while core_req=1.
REQ-008 core_gnt  out  1  combinational; core access accepted this cycle.
REQ-009 core_rvalid / core_rdata  out  1 / DATA_WIDTH  core read data return.
REQ-010 cfg_req, cfg_we, cfg_addr, cfg_wdata  in  1, 1, AW, DATA_WIDTH  configuration/readback port request and fields.
REQ-011 cfg_gnt  out  1  combinational; config access accepted this cycle.
REQ-012 cfg_rvalid / cfg_rdata  out  1 / DATA_WIDTH  config read data return.
REQ-013 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DATA_WIDTH  registered CSRAM command.
REQ-014 mem_rdata  in  DATA_WIDTH  CSRAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-015 A port's access SHALL be accepted in cycle N when its req=1 and its gnt=1; the requester holds its fields until gnt and may drop req at the following edge.
REQ-016 An accepted access SHALL drive mem_en=1 with matching mem_we/mem_addr/mem_wdata in cycle N+1; mem_en=0 in every cycle with no access accepted in the prior cycle.
REQ-017 An accepted read SHALL raise that port's rvalid for exactly one cycle in N+2, with rdata = mem_rdata; writes produce no rvalid.
REQ-018 core_rdata and cfg_rdata SHALL both carry mem_rdata; only the owning port's rvalid is asserted.
REQ-019 At most one gnt SHALL be high per cycle; throughput is one access per cycle, back-to-back accesses from the same port allowed.
REQ-020 FSM states: OPEN (no lock) and LOCKED (core owns CSRAM); reset state OPEN.
REQ-021 In OPEN, priority: cfg if cfg_req=1 and wait count = MAX_WAIT (guard, REQ-031); else core if core_req=1; else cfg if cfg_req=1.
REQ-022 OPEN -> LOCKED when core is granted with core_lock=1.
REQ-023 In LOCKED only core SHALL be granted (core_gnt = core_req); cfg_gnt=0 regardless of wait count.
REQ-024 LOCKED -> OPEN at the edge ending a cycle in which core_lock=0 and either core is granted or core_req=0.
REQ-025 Simultaneous core_req and cfg_req in OPEN with wait count below MAX_WAIT: core wins.
REQ-026 An idle cycle (no req) SHALL leave state unchanged, except as per REQ-024.

Reset
REQ-027 While rst=0: core_gnt=cfg_gnt=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, core_rvalid=cfg_rvalid=0, state OPEN, wait count 0.
REQ-028 A read accepted before reset asserts SHALL NOT produce rvalid after reset releases; lock is dropped.
REQ-029 gnt SHALL stay 0 during reset even if req=1.

Configuration
REQ-030 Macro CSRAM_ARB_STARVE_GUARD_EN compiles in the config-port starvation guard.
REQ-031 Defined: wait counter (WW bits) increments each cycle cfg_req=1 and cfg_gnt=0, saturates at MAX_WAIT, clears on cfg_gnt or cfg_req=0; at MAX_WAIT cfg beats core in OPEN only.
REQ-032 Undefined: no counter logic; strict core priority in OPEN; cfg may starve indefinitely.

Structure
REQ-033 Shared package csram_arb_pkg SHALL hold the state enum (OPEN, LOCKED), the port-id enum (NONE, CORE, CFG) for the pending-read tag, and the MAX_WAIT default.
REQ-034 One sub-module csram_arb_age_counter (saturating wait counter) SHALL be instantiated only under CSRAM_ARB_STARVE_GUARD_EN.

Verification
REQ-035 Core read addr 0x12, mem returns 0xDEAD -> core_gnt in N, mem_en/addr 0x12 in N+1, core_rvalid with 0xDEAD in N+2, cfg_rvalid=0.
REQ-036 core_req and cfg_req same cycle, guard off -> core_gnt=1, cfg_gnt=0; cfg granted the first cycle core_req=0.
REQ-037 Core read addr 5 with core_lock=1, cfg_req held high, then core write addr 5 with core_lock=0 -> cfg_gnt=0 throughout; cfg_gnt=1 the cycle after the write is granted.
REQ-038 Guard on, MAX_WAIT=3, core_req continuous, cfg_req high -> cfg_gnt at the 4th cycle of cfg_req; core resumes next cycle; counter back to 0.
REQ-039 rst=0 in cycle N+1 after cfg read accepted in N -> no cfg_rvalid in N+2; all outputs 0 until release.
REQ-040 Core back-to-back writes addr 0..3 -> mem_en=1 four consecutive cycles, addresses 0,1,2,3 in order.

Source files
------------

// File: rtl/csram_arb_pkg.sv
// Shared types and defaults for the CSRAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package csram_arb_pkg;

    // Arbiter ownership state: OPEN arbitrates normally, LOCKED reserves the
    // CSRAM for the core controller across a read-modify-write pair.
    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Tag carried with an in-flight read so the returning data is flagged
    // on the port that issued it.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        CFG  = 2'd2
    } port_id_t;

    // Default number of cycles the config port may wait before it outranks
    // the core controller (starvation guard builds only).
    localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/csram_arb_age_counter.sv
// Saturating wait counter for the config port of the CSRAM arbiter.
// Latency: count updates one cycle after the request/grant it observes.
// Backpressure: none; counts cycles where cfg_req is held but not granted.
//
// Ports: clk, rst (sync, active-low), cfg_req, cfg_gnt in; count out.
module csram_arb_age_counter
    import csram_arb_pkg::*;
#(
    parameter  int MAX_WAIT = MAX_WAIT_DEFAULT,
    localparam int WW       = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_req,
    input  logic          cfg_gnt,
    output logic [WW-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (!cfg_req || cfg_gnt) begin
            count <= '0;
        end else if (count != WW'(MAX_WAIT)) begin
            count <= count + WW'(1);
        end
    end

endmodule

// File: rtl/csram_arbiter.sv
// Two-port (core controller / config) arbiter in front of a single-port CSRAM.
// Latency: grant comb in N, registered mem command in N+1, read data + rvalid in N+2.
// Backpressure: requester holds fields until its gnt; one access per cycle total.
//
// Ports: clk, rst (sync, active-low); core_* and cfg_* request/grant/return
// ports; mem_* registered CSRAM command and mem_rdata return.
// Build option: define CSRAM_ARB_STARVE_GUARD_EN to let a config request that
// has waited MAX_WAIT cycles outrank the core (OPEN state only).
module csram_arbiter
    import csram_arb_pkg::*;
#(
    parameter  int NUM_NEURONS = 256,
    parameter  int DATA_WIDTH  = 64,
    parameter  int MAX_WAIT    = MAX_WAIT_DEFAULT,
    localparam int AW          = $clog2(NUM_NEURONS),
    localparam int WW          = $clog2(MAX_WAIT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    // core controller port
    input  logic                  core_req,
    input  logic                  core_lock,
    input  logic                  core_we,
    input  logic [AW-1:0]         core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    // configuration / readback port
    input  logic                  cfg_req,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic                  cfg_gnt,
    output logic                  cfg_rvalid,
    output logic [DATA_WIDTH-1:0] cfg_rdata,
    // CSRAM command / return
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t     state;
    arb_state_t     state_nxt;
    port_id_t       pend_id;     // owner of the read issued to the CSRAM this cycle
    logic [WW-1:0]  wait_count;
    logic           wait_at_max;

`ifdef CSRAM_ARB_STARVE_GUARD_EN
    csram_arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_counter (
        .clk     (clk),
        .rst     (rst),
        .cfg_req (cfg_req),
        .cfg_gnt (cfg_gnt),
        .count   (wait_count)
    );
`else
    // Without the guard the config port never ages; core always wins in OPEN.
    assign wait_count = '0;
`endif

    assign wait_at_max = (wait_count == WW'(MAX_WAIT));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= OPEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            OPEN:    if (core_gnt && core_lock) state_nxt = LOCKED;
            // Idle cycles with the lock still asserted keep the core's ownership.
            LOCKED:  if (!core_lock && (core_gnt || !core_req)) state_nxt = OPEN;
            default: state_nxt = OPEN;
        endcase
    end

    // Grant outputs; forced low while reset is asserted.
    always_comb begin
        core_gnt = 1'b0;
        cfg_gnt  = 1'b0;
        if (rst) begin
            case (state)
                OPEN: begin
                    if (cfg_req && wait_at_max) begin
                        cfg_gnt = 1'b1;
                    end else if (core_req) begin
                        core_gnt = 1'b1;
                    end else if (cfg_req) begin
                        cfg_gnt = 1'b1;
                    end
                end
                LOCKED:  core_gnt = core_req;
                default: ;
            endcase
        end
    end

    // Registered CSRAM command and read-return tagging.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            pend_id     <= NONE;
            core_rvalid <= 1'b0;
            cfg_rvalid  <= 1'b0;
        end else begin
            mem_en  <= core_gnt | cfg_gnt;
            pend_id <= NONE;
            if (core_gnt) begin
                mem_we    <= core_we;
                mem_addr  <= core_addr;
                mem_wdata <= core_wdata;
                if (!core_we) pend_id <= CORE;
            end else if (cfg_gnt) begin
                mem_we    <= cfg_we;
                mem_addr  <= cfg_addr;
                mem_wdata <= cfg_wdata;
                if (!cfg_we) pend_id <= CFG;
            end else begin
                mem_we <= 1'b0;
            end
            // CSRAM data for the read issued this cycle appears next cycle.
            core_rvalid <= (pend_id == CORE);
            cfg_rvalid  <= (pend_id == CFG);
        end
    end

    assign core_rdata = mem_rdata;
    assign cfg_rdata  = mem_rdata;

endmodule

// File: tb/tb_csram_arbiter.sv
// Directed self-checking bench for csram_arbiter.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_csram_arbiter;

    localparam int AW = 8;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_lock, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          cfg_req, cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_gnt, cfg_rvalid;
    logic [DW-1:0] cfg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csram_arbiter #(
        .NUM_NEURONS (256),
        .DATA_WIDTH  (DW),
        .MAX_WAIT    (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_lock   (core_lock),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .cfg_req     (cfg_req),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_gnt     (cfg_gnt),
        .cfg_rvalid  (cfg_rvalid),
        .cfg_rdata   (cfg_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later,
    // so each step below is one clock cycle.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; core_req = 1'b1; core_lock = 1'b0; core_we = 1'b0;
        core_addr = '0; core_wdata = '0;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        mem_rdata = 64'hDEAD;

        // Reset: grants held low even with both requests up.
        step(); step(); #1;
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_cfg_gnt", cfg_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_core_rvalid", core_rvalid, 0);
        chk("rst_cfg_rvalid", cfg_rvalid, 0);

        step(); rst = 1'b1; core_req = 1'b0; cfg_req = 1'b0;
        #1 chk("idle_mem_en", mem_en, 0);

        // Core read 0x12, memory returns 0xDEAD.
        step(); core_req = 1'b1; core_we = 1'b0; core_addr = 8'h12;
        #1 chk("rd_core_gnt", core_gnt, 1);
        step(); core_req = 1'b0;
        #1 chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_addr", mem_addr, 64'h12);
        chk("rd_mem_we", mem_we, 0);
        step();
        #1 chk("rd_core_rvalid", core_rvalid, 1);
        chk("rd_core_rdata", core_rdata, 64'hDEAD);
        chk("rd_cfg_rvalid", cfg_rvalid, 0);
        chk("rd_mem_en_idle", mem_en, 0);
        step();
        #1 chk("rd_rvalid_one_cycle", core_rvalid, 0);

        // Simultaneous requests: core wins, cfg served once core drops.
        step(); core_req = 1'b1; core_addr = 8'h20; cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h33;
        #1 chk("sim_core_gnt", core_gnt, 1);
        chk("sim_cfg_gnt", cfg_gnt, 0);
        step(); core_req = 1'b0;
        #1 chk("sim_cfg_gnt2", cfg_gnt, 1);
        chk("sim_core_gnt2", core_gnt, 0);
        step(); cfg_req = 1'b0;
        #1 chk("sim_mem_addr", mem_addr, 64'h33);
        chk("sim_core_rvalid", core_rvalid, 1);
        step();
        #1 chk("sim_cfg_rvalid", cfg_rvalid, 1);
        chk("sim_core_rvalid_off", core_rvalid, 0);

        // Locked read-modify-write on addr 5 while cfg waits.
        step(); core_req = 1'b1; core_lock = 1'b1; core_we = 1'b0; core_addr = 8'h05; cfg_req = 1'b1;
        cfg_we = 1'b1; cfg_addr = 8'h06; cfg_wdata = 64'hC0FFEE;
        #1 chk("lk_core_gnt", core_gnt, 1);
        chk("lk_cfg_gnt1", cfg_gnt, 0);
        step(); core_req = 1'b0;
        #1 chk("lk_cfg_gnt2", cfg_gnt, 0);
        step(); core_req = 1'b1; core_we = 1'b1; core_wdata = 64'h55; core_lock = 1'b0;
        #1 chk("lk_wr_gnt", core_gnt, 1);
        chk("lk_cfg_gnt3", cfg_gnt, 0);
        step(); core_req = 1'b0;
        #1 chk("lk_cfg_gnt_after", cfg_gnt, 1);
        chk("lk_mem_we", mem_we, 1);
        chk("lk_mem_addr", mem_addr, 64'h05);
        chk("lk_mem_wdata", mem_wdata, 64'h55);
        step(); cfg_req = 1'b0;
        #1 chk("lk_cfg_wr_addr", mem_addr, 64'h06);
        step();
        #1 chk("lk_cfg_wr_no_rvalid", cfg_rvalid, 0);

        // Back-to-back core writes addr 0..3.
        for (int i = 0; i < 5; i++) begin
            step();
            core_req = (i < 4); core_we = 1'b1; core_addr = AW'(i); core_wdata = DW'(i + 256);
            #1;
            if (i < 4) chk("b2b_gnt", core_gnt, 1);
            if (i > 0) begin
                chk("b2b_mem_en", mem_en, 1);
                chk("b2b_mem_addr", mem_addr, DW'(i - 1));
                chk("b2b_mem_wdata", mem_wdata, DW'(i - 1 + 256));
            end
        end
        step();
        #1 chk("b2b_mem_en_end", mem_en, 0);
        chk("b2b_no_rvalid", core_rvalid, 0);

`ifdef CSRAM_ARB_STARVE_GUARD_EN
        // Guard: cfg outranks continuous core traffic on its 4th waiting cycle.
        core_we = 1'b0;
        step(); core_req = 1'b1; cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h09;
        for (int i = 0; i < 3; i++) begin
            #1 chk("gd_core_first", core_gnt, 1);
            chk("gd_cfg_wait", cfg_gnt, 0);
            step();
        end
        #1 chk("gd_cfg_gnt", cfg_gnt, 1);
        chk("gd_core_held", core_gnt, 0);
        step(); cfg_req = 1'b0;
        #1 chk("gd_core_resume", core_gnt, 1);
        chk("gd_mem_addr", mem_addr, 64'h09);
        step(); cfg_req = 1'b1;
        #1 chk("gd_count_cleared", core_gnt, 1);
        step(); core_req = 1'b0; cfg_req = 1'b0;
`else
        // No guard: cfg starves under continuous core traffic.
        core_we = 1'b0;
        step(); core_req = 1'b1; cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h09;
        for (int i = 0; i < 20; i++) begin
            #1 chk("ng_cfg_starved", cfg_gnt, 0);
            step();
        end
        core_req = 1'b0;
        #1 chk("ng_cfg_gnt", cfg_gnt, 1);
        step(); cfg_req = 1'b0;
`endif

        // Lock dropped and in-flight core read discarded by reset.
        step(); core_req = 1'b1; core_lock = 1'b1; core_we = 1'b0; core_addr = 8'h07;
        #1 chk("rl_core_gnt", core_gnt, 1);
        step(); rst = 1'b0; core_req = 1'b0; cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h44;
        #1 chk("rl_gnt_in_rst", cfg_gnt, 0);
        step(); rst = 1'b1;
        #1 chk("rl_no_core_rvalid", core_rvalid, 0);
        chk("rl_open_cfg_gnt", cfg_gnt, 1);
        step(); core_lock = 1'b0; cfg_req = 1'b0;
        step();
        #1 chk("rl_cfg_rvalid", cfg_rvalid, 1);

        // cfg read accepted, then reset in the following cycle.
        step(); cfg_req = 1'b1; cfg_addr = 8'h44;
        #1 chk("rc_cfg_gnt", cfg_gnt, 1);
        step(); rst = 1'b0;
        #1 chk("rc_cfg_gnt_rst", cfg_gnt, 0);
        chk("rc_core_gnt_rst", core_gnt, 0);
        step(); cfg_req = 1'b0;
        #1 chk("rc_no_cfg_rvalid", cfg_rvalid, 0);
        chk("rc_mem_en", mem_en, 0);
        chk("rc_mem_addr", mem_addr, 0);
        chk("rc_mem_we", mem_we, 0);
        step(); rst = 1'b1;
        #1 chk("rc_post_rvalid", cfg_rvalid, 0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
